// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter: FSM state encoding,
// index width sizing and the round-robin pointer increment.
package bram_arb_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF = 3;
    localparam int ID_W        = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

    // Requester index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Advance a requester index by one, wrapping back to 0 after n-1.
    function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input int n);
        if (int'(ptr) >= (n - 1)) begin
            return 8'd0;
        end else begin
            return ptr + 8'd1;
        end
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side handshake plus the shared BRAM port, bundled for the arbiter.
// master = requesters, slave = arbiter, mem = the BRAM itself.
interface bram_port_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ*BE_W-1:0]       req_we;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;

    logic                          bram_en;
    logic [BE_W-1:0]               bram_we;
    logic [ADDR_WIDTH-1:0]         bram_addr;
    logic [DATA_WIDTH-1:0]         bram_data_in;
    logic [DATA_WIDTH-1:0]         bram_data_out;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_lock,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_lock, bram_data_out,
        output req_ready, rsp_valid, rsp_data,
        output bram_en, bram_we, bram_addr, bram_data_in
    );

    modport mem (
        input  bram_en, bram_we, bram_addr, bram_data_in,
        output bram_data_out
    );

endinterface

// File: rtl/rr_priority_select.sv
// Rotating priority encoder: picks the first set request at or after `start`,
// wrapping modulo N, and reports it both one-hot and as a binary index.
module rr_priority_select #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int               pos_s;
    logic [IDX_W-1:0] sel_s;

    // Scan N positions starting at `start`; the first hit wins.
    always_comb begin
        gnt   = {N{1'b0}};
        idx   = {IDX_W{1'b0}};
        any   = 1'b0;
        pos_s = 0;
        sel_s = {IDX_W{1'b0}};
        for (int k = 0; k < N; k++) begin
            pos_s = int'(start) + k;
            if (pos_s >= N) begin
                pos_s = pos_s - N;
            end else begin
                pos_s = pos_s;
            end
            sel_s = IDX_W'(pos_s);
            if (!any && req[sel_s]) begin
                any        = 1'b1;
                gnt[sel_s] = 1'b1;
                idx        = sel_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters, with
// locked bursts, an idle-lock timeout and per-requester read response tagging.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 17,
    parameter int DATA_WIDTH   = 32,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bram_port_arbiter_if.slave bus,
    output logic               lock_active,
    output logic               lock_timeout
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = id_width(NUM_REQ);
    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST =
        (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : {CNT_W{1'b0}};
    localparam logic TIMEOUT_EN = (LOCK_TIMEOUT != 0);

    arb_state_t             state_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       owner_r;
    logic [CNT_W-1:0]       idle_cnt_r;
    logic [NUM_REQ-1:0]     rsp_valid_r;
    logic                   lock_active_r;
    logic                   lock_timeout_r;

    logic [NUM_REQ-1:0]     elig_s;
    logic [IDX_W-1:0]       start_s;
    logic [NUM_REQ-1:0]     gnt_s;
    logic [IDX_W-1:0]       win_s;
    logic                   any_s;
    logic [ADDR_WIDTH-1:0]  win_addr_s;
    logic [DATA_WIDTH-1:0]  win_data_s;
    logic [BE_W-1:0]        win_we_s;
    logic                   win_lock_s;
    logic                   win_read_s;

    // While locked, only the owner may compete; otherwise everyone from rr_ptr.
    always_comb begin
        elig_s  = bus.req_valid;
        start_s = rr_ptr_r;
        if (state_r == LOCKED) begin
            elig_s  = bus.req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r);
            start_s = owner_r;
        end else begin
            elig_s  = bus.req_valid;
            start_s = rr_ptr_r;
        end
    end

    rr_priority_select #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_sel (
        .req   (elig_s),
        .start (start_s),
        .gnt   (gnt_s),
        .idx   (win_s),
        .any   (any_s)
    );

    // One-hot AND-OR mux of the winner's payload; all-zero when nobody wins.
    always_comb begin
        win_addr_s = {ADDR_WIDTH{1'b0}};
        win_data_s = {DATA_WIDTH{1'b0}};
        win_we_s   = {BE_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            win_addr_s = win_addr_s | (gnt_s[i] ? bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]
                                                : {ADDR_WIDTH{1'b0}});
            win_data_s = win_data_s | (gnt_s[i] ? bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH]
                                                : {DATA_WIDTH{1'b0}});
            win_we_s   = win_we_s   | (gnt_s[i] ? bus.req_we[i*BE_W +: BE_W]
                                                : {BE_W{1'b0}});
        end
        win_lock_s = |(bus.req_lock & gnt_s);
        win_read_s = any_s && (win_we_s == {BE_W{1'b0}});
    end

    assign bus.req_ready    = gnt_s;
    assign bus.bram_en      = any_s;
    assign bus.bram_we      = win_we_s;
    assign bus.bram_addr    = win_addr_s;
    assign bus.bram_data_in = win_data_s;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_data     = bus.bram_data_out;
    assign lock_active      = lock_active_r;
    assign lock_timeout     = lock_timeout_r;

    // Arbitration FSM, round-robin pointer, lock idle counter and read tagging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ARB;
            rr_ptr_r       <= {IDX_W{1'b0}};
            owner_r        <= {IDX_W{1'b0}};
            idle_cnt_r     <= {CNT_W{1'b0}};
            rsp_valid_r    <= {NUM_REQ{1'b0}};
            lock_active_r  <= 1'b0;
            lock_timeout_r <= 1'b0;
        end else begin
            lock_timeout_r <= 1'b0;
            rsp_valid_r    <= win_read_s ? gnt_s : {NUM_REQ{1'b0}};
            case (state_r)
                ARB: begin
                    if (any_s) begin
                        rr_ptr_r <= IDX_W'(ptr_inc(8'(win_s), NUM_REQ));
                        if (win_lock_s) begin
                            owner_r       <= win_s;
                            idle_cnt_r    <= {CNT_W{1'b0}};
                            state_r       <= LOCKED;
                            lock_active_r <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // An owner transfer takes precedence over a due timeout.
                    if (any_s) begin
                        idle_cnt_r <= {CNT_W{1'b0}};
                        if (!win_lock_s) begin
                            state_r       <= ARB;
                            lock_active_r <= 1'b0;
                            rr_ptr_r      <= IDX_W'(ptr_inc(8'(owner_r), NUM_REQ));
                        end
                    end else if (TIMEOUT_EN && (idle_cnt_r == IDLE_LAST)) begin
                        state_r        <= ARB;
                        lock_active_r  <= 1'b0;
                        rr_ptr_r       <= IDX_W'(ptr_inc(8'(owner_r), NUM_REQ));
                        lock_timeout_r <= 1'b1;
                        idle_cnt_r     <= {CNT_W{1'b0}};
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r       <= ARB;
                    lock_active_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomised scoreboard bench for bram_port_arbiter: a behavioural arbitration
// model predicts grants and BRAM drive, and a monitor checks tagged read data.
module tb_bram_port_arbiter;

    localparam int N   = 3;
    localparam int AW  = 17;
    localparam int DW  = 32;
    localparam int BEW = DW / 8;
    localparam int T   = 16;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [BEW-1:0] we;
        logic           lock;
    } txn_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lock_active;
    logic lock_timeout;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_port_arbiter #(
        .NUM_REQ      (N),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .LOCK_TIMEOUT (T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .lock_active  (lock_active),
        .lock_timeout (lock_timeout)
    );

    txn_t          rq [N][$];
    exp_t          sb [$];
    exp_t          me;
    logic [DW-1:0] bmem [256];
    logic [DW-1:0] mmem [256];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            started = 1'b0;

    // Reference model state, in plain integers.
    bit m_locked;
    int m_ptr;
    int m_owner;
    int m_idle;
    bit m_tout;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first BRAM: data_out shows the pre-write contents one cycle later.
    always @(posedge clk) begin
        if (bus.bram_en) begin
            bus.bram_data_out <= bmem[bus.bram_addr[7:0]];
            for (int b = 0; b < BEW; b++) begin
                if (bus.bram_we[b]) bmem[bus.bram_addr[7:0]][b*8 +: 8] <= bus.bram_data_in[b*8 +: 8];
            end
        end
    end

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'(a) * 32'h0001_0001;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_ptr    = 0;
        m_owner  = 0;
        m_idle   = 0;
        m_tout   = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) rq[i].delete();
    endtask

    task automatic push(input int i, input int addr, input logic [DW-1:0] wd,
                        input logic [BEW-1:0] we, input logic lk);
        txn_t t;
        t.addr  = AW'(addr);
        t.wdata = wd;
        t.we    = we;
        t.lock  = lk;
        rq[i].push_back(t);
    endtask

    task automatic push_rand(input int i);
        txn_t t;
        t.addr  = AW'($urandom_range(0, 255));
        t.wdata = $urandom;
        t.we    = ($urandom_range(0, 1) == 1) ? BEW'($urandom_range(1, 15)) : {BEW{1'b0}};
        t.lock  = ($urandom_range(0, 4) == 0);
        rq[i].push_back(t);
    endtask

    function automatic logic [N-1:0] valid_vec();
        logic [N-1:0] v;
        v = {N{1'b0}};
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) v = v | onehot(i);
        return v;
    endfunction

    // Spec rule: locked -> owner only; otherwise first valid from rr_ptr, wrapping.
    function automatic int model_win(input logic [N-1:0] v);
        if (m_locked) return bit_of(v, m_owner) ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (bit_of(v, (m_ptr + k) % N)) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        logic [N-1:0]    v;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        logic [N*BEW-1:0] w;
        logic [N-1:0]    l;
        v = {N{1'b0}}; a = {(N*AW){1'b0}}; d = {(N*DW){1'b0}};
        w = {(N*BEW){1'b0}}; l = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                v[i]              = 1'b1;
                a[i*AW +: AW]     = rq[i][0].addr;
                d[i*DW +: DW]     = rq[i][0].wdata;
                w[i*BEW +: BEW]   = rq[i][0].we;
                l[i]              = rq[i][0].lock;
            end
        end
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_we    = w;
        bus.req_lock  = l;
    endtask

    task automatic check_step();
        logic [N-1:0] v;
        int           w;
        txn_t         t;
        v = valid_vec();
        w = model_win(v);
        chk("req_ready", 64'(bus.req_ready), 64'((w >= 0) ? onehot(w) : {N{1'b0}}));
        chk("lock_active", 64'(lock_active), 64'(m_locked));
        chk("lock_timeout", 64'(lock_timeout), 64'(m_tout));
        m_tout = 1'b0;
        if (w >= 0) begin
            t = rq[w].pop_front();
            chk("bram_en", 64'(bus.bram_en), 64'(1'b1));
            chk("bram_addr", 64'(bus.bram_addr), 64'(t.addr));
            chk("bram_we", 64'(bus.bram_we), 64'(t.we));
            chk("bram_data_in", 64'(bus.bram_data_in), 64'(t.wdata));
            if (t.we == {BEW{1'b0}}) begin
                sb.push_back('{id: w, data: mmem[t.addr[7:0]], cyc: cyc});
            end else begin
                for (int b = 0; b < BEW; b++)
                    if (t.we[b]) mmem[t.addr[7:0]][b*8 +: 8] = t.wdata[b*8 +: 8];
            end
            if (!m_locked) begin
                m_ptr = (w + 1) % N;
                if (t.lock) begin
                    m_locked = 1'b1;
                    m_owner  = w;
                    m_idle   = 0;
                end
            end else begin
                m_idle = 0;
                if (!t.lock) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end
            end
        end else begin
            chk("bram_en idle", 64'(bus.bram_en), 64'(1'b0));
            chk("bram_addr idle", 64'(bus.bram_addr), 64'(0));
            chk("bram_we idle", 64'(bus.bram_we), 64'(0));
            chk("bram_data_in idle", 64'(bus.bram_data_in), 64'(0));
            if (m_locked) begin
                if (T != 0 && m_idle == T - 1) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                    m_tout   = 1'b1;
                    m_idle   = 0;
                end else begin
                    m_idle++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check_step();
    endtask

    // Monitor: a read accepted in cycle c must answer, tagged, in cycle c+1.
    always @(negedge clk) begin
        if (started) begin
            if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
                me = sb.pop_front();
                chk("rsp_valid", 64'(bus.rsp_valid), 64'(onehot(me.id)));
                chk("rsp_data", 64'(bus.rsp_data), 64'(me.data));
            end else begin
                chk("rsp_valid quiet", 64'(bus.rsp_valid), 64'(0));
            end
        end
    end

    initial begin
        int pend;
        for (int a = 0; a < 256; a++) begin
            bmem[a] = init_word(a);
            mmem[a] = init_word(a);
        end
        model_reset();
        drive();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        started = 1'b1;
        step();

        // Simultaneous reads from 0 and 2.
        push(0, 'h10, 32'h0, 4'h0, 1'b0);
        push(2, 'h20, 32'h0, 4'h0, 1'b0);
        repeat (3) step();

        // Everyone holds valid: strict rotation, port busy every cycle.
        for (int i = 0; i < N; i++) begin
            push(i, $urandom_range(0, 255), 32'h0, 4'h0, 1'b0);
            push(i, $urandom_range(0, 255), 32'h0, 4'h0, 1'b0);
        end
        repeat (7) step();

        // Byte-masked write then readback.
        push(1, 5, 32'hDEAD_BEEF, 4'b0101, 1'b0);
        push(1, 5, 32'h0, 4'h0, 1'b0);
        repeat (3) step();

        // Locked 4-beat burst from 2 while 0 waits.
        push(2, 30, 32'h1111_1111, 4'hF, 1'b1);
        push(2, 30, 32'h0, 4'h0, 1'b1);
        push(2, 31, 32'h2222_2222, 4'h3, 1'b1);
        push(2, 31, 32'h0, 4'h0, 1'b0);
        step();
        push(0, 40, 32'h0, 4'h0, 1'b0);
        repeat (6) step();

        // Owner locks then goes idle: timeout releases to requester 1.
        push(0, 50, 32'h0, 4'h0, 1'b1);
        step();
        push(1, 60, 32'h0, 4'h0, 1'b0);
        repeat (T + 4) step();

        // Reset right after a read accept drops its response.
        push(0, 70, 32'h0, 4'h0, 1'b0);
        step();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        drive();
        @(negedge clk);
        chk("lock_active in reset", 64'(lock_active), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(0, 71, 32'h0, 4'h0, 1'b0);
        push(1, 72, 32'h0, 4'h0, 1'b0);
        repeat (3) step();

        // Randomised traffic.
        repeat (400) begin
            for (int i = 0; i < N; i++)
                if (rq[i].size() == 0 && $urandom_range(0, 1) == 1) push_rand(i);
            step();
        end

        // Drain, bounded.
        for (int g = 0; g < 200; g++) begin
            pend = 0;
            for (int i = 0; i < N; i++) pend += rq[i].size();
            if (pend == 0 && sb.size() == 0) break;
            step();
        end
        pend = 0;
        for (int i = 0; i < N; i++) pend += rq[i].size();
        chk("drain pending", 64'(pend + sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

- Shares one port of the dual-port weight/activation BRAM between `NUM_REQ` requesters, e.g. the host loader, the weight fetcher and the activation writer.
- Uses round-robin arbitration with optional locked bursts and a lock timeout.
- Drives the BRAM port's `en`/`we`/`addr`/`data_in` and routes the single-cycle read data back to the requester that issued the read.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (2..8)
- `ADDR_WIDTH`, 17, BRAM word-address width
- `DATA_WIDTH`, 32, BRAM data width; byte-enable width `BE_W = DATA_WIDTH/8`
- `LOCK_TIMEOUT`, 16, idle cycles in LOCKED before forced release; 0 disables the timeout

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_REQ  request valid, one bit per requester
- `req_ready`  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data
- `req_we`  in  NUM_REQ*BE_W  packed byte enables; all-zero means read
- `req_lock`  in  NUM_REQ  keep the grant after this transfer
- `rsp_valid`  out  NUM_REQ  read data valid for requester i
- `rsp_data`  out  DATA_WIDTH  read data, shared by all requesters
- `bram_en`  out  1  BRAM port enable
- `bram_we`  out  BE_W  BRAM byte write enable
- `bram_addr`  out  ADDR_WIDTH  BRAM address
- `bram_data_in`  out  DATA_WIDTH  BRAM write data
- `bram_data_out`  in  DATA_WIDTH  BRAM read data, valid one cycle after `bram_en`
- `lock_active`  out  1  FSM is in LOCKED
- `lock_timeout`  out  1  one-cycle pulse on forced release

## Operation
States: ARB and LOCKED.

ARB:
- The winner is the first valid requester found scanning from `rr_ptr` upward, wrapping modulo `NUM_REQ`.
- `req_ready[winner]` is set combinationally in the same cycle, and the BRAM port is driven from the winner's slice.
- On the transfer:
  - `rr_ptr` ← winner+1, wrapping at `NUM_REQ`.
  - If `req_lock[winner]` is set, `owner` ← winner and the FSM goes to LOCKED.

LOCKED:
- Only `owner` can be granted; all other requests stall.
- An owner transfer with `req_lock=0` returns the FSM to ARB and sets `rr_ptr` ← owner+1.
- Each cycle without an owner transfer increments `idle_cnt`. Any owner transfer clears it.
- If `idle_cnt` reaches `LOCK_TIMEOUT-1` (and `LOCK_TIMEOUT` ≠ 0), the FSM returns to ARB next cycle, `rr_ptr` ← owner+1 and `lock_timeout` pulses.

Outputs and data path:
- No grant: `bram_en`=0, `bram_we`=0, `bram_addr`=0, `bram_data_in`=0.
- Reads are transfers with `req_we`=0. A read sets a registered `rsp_pending` and `rsp_id`. The next cycle drives `rsp_valid[rsp_id]`=1 with `rsp_data`=`bram_data_out` (combinational passthrough).
- Writes produce no response.
- A read followed by a write to the same address on the next cycle returns the old data.
- Back-to-back reads from different requesters yield a response every cycle, each tagged to the correct requester.

## Timing
- Reset values: state ARB, `rr_ptr`=0 (requester 0 has first priority), `owner`=0, `idle_cnt`=0.
- Registered outputs reset to 0: `rsp_valid`, `lock_active`, `lock_timeout`.
- Reset asserted while a read is in flight drops that response.
- Grant latency is 0 cycles: accept and BRAM access happen in the same cycle. Read latency is 1 cycle from accept to `rsp_valid`.
- Throughput is one transfer per cycle.
- `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- A requester holds `req_valid` and its payload stable until `req_ready`.
- `lock_active` is registered and equals (state == LOCKED).
- If a timeout release and an owner transfer coincide, the transfer wins: it is granted, `idle_cnt` clears and no timeout fires.
- A transfer with lock set in LOCKED keeps the lock.

## Structure
- Package `bram_arb_pkg` holds:
  - the state enum `arb_state_t` {ARB, LOCKED}
  - `ID_W = $clog2(NUM_REQ)`, minimum 1
  - the pointer-increment-with-wrap function
- Sub-module `rr_priority_select`: combinational rotating priority encoder. Inputs are the request vector and the start pointer; outputs are a one-hot grant and the binary index.
- The top level holds the FSM, the pointer, the lock counter, response tagging and the payload muxes.

## Test plan
- Reset; requesters 0 and 2 issue reads of addr 0x10 and 0x20 together:
  - requester 0 is granted in cycle 0 and requester 2 in cycle 1;
  - `rsp_valid` is 0b001 then 0b100, with correct data.
- All three requesters hold `req_valid` for 6 cycles: grants follow 0,1,2,0,1,2 and `bram_en` stays 1 throughout.
- Requester 1 writes 0xDEADBEEF with `we`=0b0101 to addr 5, then reads it: `rsp_data` is 0x00AD00EF and only `rsp_valid[1]` is set.
- Requester 2 runs a locked 4-beat burst (`lock`=1,1,1,0) while requester 0 is valid:
  - requester 0 is stalled until beat 4, then granted the next cycle;
  - `lock_active` is high during the burst.
- Requester 0 locks and then drops valid, with `LOCK_TIMEOUT`=16: `lock_timeout` pulses after 16 idle cycles, then requester 1's pending request is granted.
- Reset asserted the cycle after a read accept: no `rsp_valid`; state is ARB and `rr_ptr` is 0 after release.
